// File: rtl/swan_sbox_layer_serial.sv
// swan_sbox_layer_serial: bitsliced 4-bit S-box layer over one SWAN128 half-state, LANES positions per cycle
module swan_sbox_layer_serial #(
  parameter int BLOCK_SIZE  = 128,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int LANES       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y
);
  localparam int PW = $clog2(COLUMN_SIZE) + 1;
  localparam int IW = $clog2(SIDE_SIZE);
  localparam logic [63:0] SBOX = 64'h1A4C6F392DB7508E;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [0:SIDE_SIZE-1] st, st_sub, st_nxt;
  logic [PW-1:0] pos, pos_nxt;
  logic last;
  logic [IW-1:0] idx [LANES];
  logic [3:0] sub [LANES];
  function automatic logic [3:0] sbox(input logic [3:0] n);
    return 4'(SBOX >> (4 * (15 - int'(n))));
  endfunction
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign idx[g] = IW'(pos) + IW'(g);
    assign sub[g] = sbox({st[idx[g]], st[idx[g] + IW'(COLUMN_SIZE)],
                          st[idx[g] + IW'(2 * COLUMN_SIZE)], st[idx[g] + IW'(3 * COLUMN_SIZE)]});
  end
  // substituted nibbles are written back in place across the four rows
  always_comb begin
    st_sub = st;
    for (int l = 0; l < LANES; l++) begin
      st_sub[idx[l]]                          = sub[l][3];
      st_sub[idx[l] + IW'(COLUMN_SIZE)]       = sub[l][2];
      st_sub[idx[l] + IW'(2 * COLUMN_SIZE)]   = sub[l][1];
      st_sub[idx[l] + IW'(3 * COLUMN_SIZE)]   = sub[l][0];
    end
  end
  assign last = (pos + PW'(LANES)) == PW'(COLUMN_SIZE);
  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    pos_nxt   = '0;
    state_nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                (out_ready ? IDLE : DONE);
    st_nxt    = (state == IDLE && in_valid) ? x : state == BUSY ? st_sub : st;
    pos_nxt   = state == BUSY ? pos + PW'(LANES) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '0;
      pos   <= '0;
    end else begin
      state <= state_nxt;
      st    <= st_nxt;
      pos   <= pos_nxt;
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign y         = st;
endmodule

// File: tb/tb_swan_sbox_layer_serial.sv
// tb_swan_sbox_layer_serial: randomized checks of the serial S-box layer against a nibble-table model
module tb_swan_sbox_layer_serial;
  logic clk = 0, rst_n, in_valid, out_ready, in_ready, out_valid;
  logic [0:63] x, y;
  logic iv_x, ir1, ov1, ir16, ov16;
  logic [0:63] xx, y1, y16;
  int tests = 0, fails = 0;
  localparam int TBL [16] = '{1, 10, 4, 12, 6, 15, 3, 9, 2, 13, 11, 7, 5, 0, 8, 14};

  always #5 clk = ~clk;

  swan_sbox_layer_serial dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y));
  swan_sbox_layer_serial #(.LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir1),
    .x(xx), .out_valid(ov1), .out_ready(1'b1), .y(y1));
  swan_sbox_layer_serial #(.LANES(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir16),
    .x(xx), .out_valid(ov16), .out_ready(1'b1), .y(y16));

  function automatic logic [0:63] model(input logic [0:63] v);
    logic [0:63] r;
    int n, s;
    for (int j = 0; j < 16; j++) begin
      n = 8 * int'(v[j]) + 4 * int'(v[16+j]) + 2 * int'(v[32+j]) + int'(v[48+j]);
      s = TBL[n];
      r[j] = s[3];
      r[16+j] = s[2];
      r[32+j] = s[1];
      r[48+j] = s[0];
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [0:63] v, input logic [63:0] exp);
    int n;
    in_valid = 1;
    x = v;
    tick();
    in_valid = 0;
    x = rnd64();
    wait_out(n);
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_y"}, y, exp);
    tick();
    chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n, bad, l1, l4, l16;
    logic [0:63] v, v2, r1, r4, r16;
    rst_n = 0; in_valid = 0; iv_x = 0; x = '0; xx = '0; out_ready = 1;
    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", y, 64'd0);
    rst_n = 1;
    tick();
    run("zero", 64'h0, 64'h0000_0000_0000_FFFF);
    run("ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_0000);
    run("msb", 64'h8000_0000_0000_0000, 64'h0000_0000_8000_7FFF);
    // backpressure with a competing request held during DONE
    out_ready = 0;
    v = rnd64();
    v2 = rnd64();
    in_valid = 1;
    x = v;
    tick();
    in_valid = 0;
    wait_out(n);
    chk("bp_lat", 64'(n), 64'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      x = v2;
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_y", y, model(v));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    tick();
    chk("bp_hs_idle", 64'(in_ready), 64'd1);
    chk("bp_hs_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 0;
    wait_out(n);
    chk("bp2_lat", 64'(n), 64'd4);
    chk("bp2_y", y, model(v2));
    tick();
    // asynchronous reset two cycles into BUSY
    in_valid = 1;
    x = rnd64();
    tick();
    in_valid = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_y", y, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1;
    bad = 0;
    repeat (8) begin
      tick();
      if (out_valid || y != 0) bad++;
    end
    chk("arst_no_pulse", 64'(bad), 64'd0);
    v = rnd64();
    run("post_rst", v, model(v));
    // random vectors across LANES=1, 4, 16
    repeat (20) begin
      v = rnd64();
      chk("lanes_idle", {ir1, in_ready, ir16}, 3'b111);
      in_valid = 1; iv_x = 1; x = v; xx = v;
      tick();
      in_valid = 0; iv_x = 0; x = rnd64(); xx = rnd64();
      l1 = 0; l4 = 0; l16 = 0; r1 = '0; r4 = '0; r16 = '0;
      for (int k = 1; k <= 30; k++) begin
        if (ov1 && l1 == 0) begin l1 = k - 1; r1 = y1; end
        if (out_valid && l4 == 0) begin l4 = k - 1; r4 = y; end
        if (ov16 && l16 == 0) begin l16 = k - 1; r16 = y16; end
        tick();
      end
      chk("l1_lat", 64'(l1), 64'd16);
      chk("l4_lat", 64'(l4), 64'd4);
      chk("l16_lat", 64'(l16), 64'd1);
      chk("l1_y", r1, model(v));
      chk("l4_y", r4, model(v));
      chk("l16_y", r16, model(v));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
